lsu_seq: RTL and testbench

- Load/store sequencer between the execute/memory pipeline stage and the single-ported data memory.
- Accepts one load or store per handshake and issues aligned word accesses with byte enables.
- Splits misaligned halfword/word accesses into two consecutive word beats.
- Merges and extends read data, then returns one response per request.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_seq_lane_align.sv | 49 ++++
 rtl/lsu_seq.sv | 252 +++++++++++++++++++++++++
 tb/tb_lsu_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: FSM states, rw_type bit positions,
// access size masks and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE0 = 3'd1;
  localparam logic [2:0] ST_WAIT0  = 3'd2;
  localparam logic [2:0] ST_ISSUE1 = 3'd3;
  localparam logic [2:0] ST_WAIT1  = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam int RW_U = 3;
  localparam int RW_W = 2;
  localparam int RW_H = 1;
  localparam int RW_B = 0;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  function automatic logic is_legal(input logic [2:0] t);
    return (t == 3'b100) || (t == 3'b010) || (t == 3'b001);
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] t);
    logic [3:0] m;
    m = 4'b0000;
    if (t[RW_W]) m = SZ_W;
    else if (t[RW_H]) m = SZ_H;
    else if (t[RW_B]) m = SZ_B;
    else m = 4'b0000;
    return m;
  endfunction

  // An access needs two word beats when its bytes spill past the end of the word.
  function automatic logic crosses_word(input logic [2:0] t, input logic [1:0] a);
    return (t[RW_H] && (a == 2'd3)) || (t[RW_W] && (a != 2'd0));
  endfunction

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/lsu_seq_lane_align.sv
// lane_align: combinational byte-lane placement for stores and read-window
// extraction plus sign/zero extension for loads.
module lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_off,
  input  logic [3:0]  i_st_smask,
  input  logic [31:0] i_st_wdata,
  input  logic        i_st_hi,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_off,
  input  logic [3:0]  i_ld_smask,
  input  logic        i_ld_uns,
  input  logic [31:0] i_ld_rd0,
  input  logic [31:0] i_ld_rd1,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_lane;
  logic [63:0] w_wwin;
  logic [63:0] w_rwin;
  logic [31:0] w_raw;

  // Store side: 8-lane mask and 64-bit write window; i_st_hi picks the second beat's half.
  always_comb begin
    w_lane = {4'b0000, i_st_smask} << i_st_off;
    w_wwin = {32'h0000_0000, i_st_wdata} << {i_st_off, 3'b000};
    if (i_st_hi) begin
      o_st_be    = w_lane[7:4];
      o_st_wdata = w_wwin[63:32];
    end else begin
      o_st_be    = w_lane[3:0];
      o_st_wdata = w_wwin[31:0];
    end
  end

  // Load side: shift the two-word window down to the access offset, trim, then extend.
  always_comb begin
    w_rwin = {i_ld_rd1, i_ld_rd0} >> {i_ld_off, 3'b000};
    w_raw  = w_rwin[31:0] & be_to_mask(i_ld_smask);
    case (i_ld_smask)
      SZ_B:    o_ld_data = i_ld_uns ? w_raw : {{24{w_raw[7]}}, w_raw[7:0]};
      SZ_H:    o_ld_data = i_ld_uns ? w_raw : {{16{w_raw[15]}}, w_raw[15:0]};
      default: o_ld_data = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between the memory stage and a single-ported data RAM.
// Define LSU_MISALIGN_SPLIT_EN to split cross-word accesses into two beats; otherwise they fault.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_we;
  logic              r_uns;
  logic [3:0]        r_smask;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd0;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic              r_split;
`endif

  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_idle;
  logic              w_acc;
  logic              w_in_legal;
  logic              w_in_cross;
  logic              w_in_err;
  logic [3:0]        w_in_smask;
  logic [1:0]        w_st_off;
  logic [3:0]        w_st_smask;
  logic [31:0]       w_st_wdata;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wd;
  logic [31:0]       w_ld_rd0;
  logic [31:0]       w_ld_rd1;
  logic [31:0]       w_ld_data;

  assign req_ready  = w_idle & ~rst;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  // Request decode; in IDLE the lane logic looks at the live request so beat 0 registers on accept.
  always_comb begin
    w_idle     = (r_state == ST_IDLE);
    w_acc      = req_valid & req_ready;
    w_in_smask = size_mask(req_type[2:0]);
    w_in_legal = is_legal(req_type[2:0]);
    w_in_cross = crosses_word(req_type[2:0], req_addr[1:0]);
`ifdef LSU_MISALIGN_SPLIT_EN
    w_in_err   = ~w_in_legal;
`else
    w_in_err   = ~w_in_legal | w_in_cross;
`endif
    if (w_idle) begin
      w_st_off   = req_addr[1:0];
      w_st_smask = w_in_smask;
      w_st_wdata = req_wdata;
    end else begin
      w_st_off   = r_addr[1:0];
      w_st_smask = r_smask;
      w_st_wdata = r_wdata;
    end
    w_ld_rd0 = (r_state == ST_WAIT0) ? mem_rdata : r_rd0;
`ifdef LSU_MISALIGN_SPLIT_EN
    w_ld_rd1 = (r_state == ST_WAIT1) ? mem_rdata : 32'h0000_0000;
`else
    w_ld_rd1 = 32'h0000_0000;
`endif
  end

  lane_align u_lane_align (
    .i_st_off   (w_st_off),
    .i_st_smask (w_st_smask),
    .i_st_wdata (w_st_wdata),
    .i_st_hi    (r_state == ST_WAIT0),
    .o_st_be    (w_st_be),
    .o_st_wdata (w_st_wd),
    .i_ld_off   (r_addr[1:0]),
    .i_ld_smask (r_smask),
    .i_ld_uns   (r_uns),
    .i_ld_rd0   (w_ld_rd0),
    .i_ld_rd1   (w_ld_rd1),
    .o_ld_data  (w_ld_data)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) w_next = w_in_err ? ST_RESP : ST_ISSUE0;
        else w_next = ST_IDLE;
      end
      ST_ISSUE0: begin
        if (mem_gnt) w_next = ST_WAIT0;
        else w_next = ST_ISSUE0;
      end
      ST_WAIT0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (mem_rvalid) w_next = r_split ? ST_ISSUE1 : ST_RESP;
        else w_next = ST_WAIT0;
`else
        if (mem_rvalid) w_next = ST_RESP;
        else w_next = ST_WAIT0;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_ISSUE1: begin
        if (mem_gnt) w_next = ST_WAIT1;
        else w_next = ST_ISSUE1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) w_next = ST_RESP;
        else w_next = ST_WAIT1;
      end
`endif
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, request capture, memory beat registers and the response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_smask      <= 4'b0000;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= {DATA_W{1'b0}};
      r_rd0        <= {DATA_W{1'b0}};
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split      <= 1'b0;
`endif
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_addr   <= {(ADDR_W-2){1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_we    <= req_we;
            r_uns   <= req_type[RW_U];
            r_smask <= w_in_smask;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split <= w_in_cross;
`endif
            if (w_in_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= {DATA_W{1'b0}};
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_addr  <= req_addr[ADDR_W-1:2];
              r_mem_we    <= req_we;
              r_mem_be    <= w_st_be;
              r_mem_wdata <= w_st_wd;
            end
          end
        end
        ST_ISSUE0: begin
          if (mem_gnt) r_mem_req <= 1'b0;
        end
        ST_WAIT0: begin
          if (mem_rvalid) begin
            r_rd0 <= mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_split) begin
              // Second beat targets the next word; the 30-bit word address wraps naturally.
              r_mem_req   <= 1'b1;
              r_mem_addr  <= r_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
              r_mem_be    <= w_st_be;
              r_mem_wdata <= w_st_wd;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= r_we ? {DATA_W{1'b0}} : w_ld_data;
            end
`else
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? {DATA_W{1'b0}} : w_ld_data;
`endif
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ST_ISSUE1: begin
          if (mem_gnt) r_mem_req <= 1'b0;
        end
        ST_WAIT1: begin
          if (mem_rvalid) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? {DATA_W{1'b0}} : w_ld_data;
          end
        end
`endif
        ST_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= {DATA_W{1'b0}};
        end
        default: begin
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed self-checking bench for lsu_seq; outputs sampled on the falling edge.
module tb_lsu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // One request served by a zero-wait memory: grant on the first request cycle, data the next.
  task automatic access(input logic we, input logic [3:0] typ, input logic [31:0] addr,
                        input logic [31:0] wd, input int beats,
                        input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                        input logic [31:0] rd0,
                        input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                        input logic [31:0] rd1,
                        input logic [31:0] exp_rd, input string tag);
    logic [31:0] ea;
    logic [3:0]  eb;
    logic [31:0] ew;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      ea = (b == 0) ? a0 : a1;
      eb = (b == 0) ? be0 : be1;
      ew = (b == 0) ? wd0 : wd1;
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_addr"}, {2'b00, mem_addr}, ea);
      chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, eb});
      chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
      if (we) chk({tag, "_wdata"}, mem_wdata & lane_bits(eb), ew);
      chk({tag, "_no_resp_issue"}, {31'd0, resp_valid}, 32'd0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_no_resp_wait"}, {31'd0, resp_valid}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = (b == 0) ? rd0 : rd1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Request expected to fault at once without memory traffic.
  task automatic err_access(input logic we, input logic [3:0] typ, input logic [31:0] addr,
                            input string tag);
    req_valid = 1'b1; req_we = we; req_type = typ; req_addr = addr; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_still_no_mem"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 4'b0000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", {2'b00, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(1'b0, 4'b0100, 32'h0000_1000, 32'h0, 1, 32'h400, 4'b1111, 32'h0, 32'h8899_AABB,
           32'h0, 4'b0000, 32'h0, 32'h0, 32'h8899_AABB, "ldw");
    access(1'b0, 4'b0010, 32'h0000_1002, 32'h0, 1, 32'h400, 4'b1100, 32'h0, 32'h80FF_1234,
           32'h0, 4'b0000, 32'h0, 32'h0, 32'hFFFF_80FF, "ldh_s");
    access(1'b0, 4'b1010, 32'h0000_1002, 32'h0, 1, 32'h400, 4'b1100, 32'h0, 32'h80FF_1234,
           32'h0, 4'b0000, 32'h0, 32'h0, 32'h0000_80FF, "ldhu");
    access(1'b1, 4'b0001, 32'h0000_2003, 32'h0000_00A5, 1, 32'h800, 4'b1000, 32'hA500_0000,
           32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, "stb");
    access(1'b0, 4'b0001, 32'h0000_1001, 32'h0, 1, 32'h400, 4'b0010, 32'h0, 32'h4433_8211,
           32'h0, 4'b0000, 32'h0, 32'h0, 32'hFFFF_FF82, "ldb_s");
    access(1'b0, 4'b0010, 32'h0000_1001, 32'h0, 1, 32'h400, 4'b0110, 32'h0, 32'h4433_8211,
           32'h0, 4'b0000, 32'h0, 32'h0, 32'h0000_3382, "ldh_a1");

    err_access(1'b0, 4'b0110, 32'h0000_1000, "ill_wh");
    err_access(1'b1, 4'b0000, 32'h0000_1000, "ill_none");

`ifdef LSU_MISALIGN_SPLIT_EN
    access(1'b0, 4'b0100, 32'h0000_1001, 32'h0, 2, 32'h400, 4'b1110, 32'h0, 32'h4433_2211,
           32'h401, 4'b0001, 32'h0, 32'h8877_6655, 32'h5544_3322, "ldw_split");
    access(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 32'h3FFF_FFFF, 4'b1000, 32'hEF00_0000,
           32'h0, 32'h0, 4'b0001, 32'h0000_00BE, 32'h0, 32'h0, "sth_wrap");
`else
    err_access(1'b0, 4'b0100, 32'h0000_1001, "ldw_mis");
    err_access(1'b1, 4'b0010, 32'hFFFF_FFFF, "sth_mis");
`endif

    // Grant stall with a competing request held, then reset while waiting for data.
    req_valid = 1'b1; req_we = 1'b0; req_type = 4'b0100; req_addr = 32'h0000_3000;
    @(negedge clk);
    req_addr = 32'h0000_5000;
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
      chk("stall_addr", {2'b00, mem_addr}, 32'h0000_0C00);
      chk("stall_be", {28'd0, mem_be}, 32'h0000_000F);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("wait0_req_drop", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_resp", {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rvalid_resp", {31'd0, resp_valid}, 32'd0);
    chk("late_rvalid_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("late_rvalid_resp2", {31'd0, resp_valid}, 32'd0);

    access(1'b0, 4'b0100, 32'h0000_1000, 32'h0, 1, 32'h400, 4'b1111, 32'h0, 32'h0102_0304,
           32'h0, 4'b0000, 32'h0, 32'h0, 32'h0102_0304, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
